mem_port_arbiter: RTL and testbench

- Parametrised two-requester memory arbiter for the multicycle core.
- Instruction-fetch port and data (load/store) port share one backing memory that uses a req/ack handshake with variable wait states.
- Replaces the fixed-latency, always-ready instruction/data memories with a stallable interface.
- Timeout detection and a registered response path are included.

---
 rtl/mem_arb_pkg.sv | 32 +++
 rtl/mem_arb_timeout.sv | 50 +++++
 rtl/mem_port_arbiter.sv | 228 ++++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared definitions for the two-requester memory arbiter: FSM state
// encoding, grant encoding and the arbitration helper used in IDLE.
// -----------------------------------------------------------------------------
package mem_arb_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE     = 2'd0;
  localparam state_t WAIT_MEM = 2'd1;
  localparam state_t RESP     = 2'd2;

  localparam logic GNT_FETCH = 1'b0;
  localparam logic GNT_DATA  = 1'b1;

  // Chooses the port to serve. On a tie, fixed priority gives data the
  // grant; round-robin gives it to the port that was not granted last.
  function automatic logic pick_grant(input logic fetch_req,
                                      input logic data_req,
                                      input logic last_gnt,
                                      input logic rr_en);
    if (fetch_req && data_req) begin
      return rr_en ? ~last_gnt : GNT_DATA;
    end else if (data_req) begin
      return GNT_DATA;
    end else begin
      return GNT_FETCH;
    end
  endfunction

endpackage

// File: rtl/mem_arb_timeout.sv
// -----------------------------------------------------------------------------
// mem_arb_timeout
// Wait-state counter for one memory access. Counts while enabled and stops
// at TIMEOUT-1, so it never wraps. TIMEOUT = 0 disables expiry entirely.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous reset, active-low
//   clr_i      synchronous clear (held while no access is outstanding)
//   en_i       count enable (access outstanding)
//   expired_o  high in the cycle the count sits at TIMEOUT-1 while enabled
// -----------------------------------------------------------------------------
module mem_arb_timeout #(
  parameter int TIMEOUT = 64,
  parameter int TO_W    = 7
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam bit              TO_ON = (TIMEOUT != 0);
  localparam logic [TO_W-1:0] LAST  = TO_W'(TO_ON ? TIMEOUT - 1 : 0);

  logic [TO_W-1:0] cnt_q, cnt_d;

  assign expired_o = TO_ON && en_i && (cnt_q == LAST);

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (TO_ON && en_i && !expired_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one req/ack memory between an instruction-fetch port and a data
// (load/store) port. One access is in flight at a time; the memory side is
// fully registered and each completed access gets a one-cycle ack in RESP.
//
// Build option:
//   MEM_ARB_RR_EN  defined   -> round-robin on simultaneous requests
//                  undefined -> fixed priority, data over fetch
//
// Ports:
//   clk, rst                  clock / asynchronous active-low reset
//   if_req, if_addr           fetch request (level) and address
//   if_rdata, if_ack          fetch data (held) and completion pulse
//   d_req, d_we, d_addr,
//   d_wdata                   data request, store flag, address, store data
//   d_rdata, d_ack            load data (held) and completion pulse
//   m_req, m_we, m_addr,
//   m_wdata                   registered memory request side
//   m_rdata, m_ack            memory read data and completion pulse
//   busy                      high whenever the FSM is not in IDLE
//   err                       sticky timeout flag, cleared only by reset
// -----------------------------------------------------------------------------
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 64,
  parameter int TO_W    = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_ack,
  output logic              busy,
  output logic              err
);

  state_t state_q, state_d;

  logic              m_req_q,    m_req_d;
  logic              m_we_q,     m_we_d;
  logic [ADDR_W-1:0] m_addr_q,   m_addr_d;
  logic [DATA_W-1:0] m_wdata_q,  m_wdata_d;
  logic              gnt_q,      gnt_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q,  d_rdata_d;
  logic              err_q,      err_d;

  logic any_req;
  logic grant_fire;
  logic gnt_new;
  logic last_gnt;
  logic to_expired;

  assign any_req    = if_req | d_req;
  assign grant_fire = (state_q == IDLE) && any_req;

`ifdef MEM_ARB_RR_EN
  localparam bit RR_EN = 1'b1;

  // Remembers which port won the most recent grant; a tie goes the other way.
  logic last_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_q <= GNT_FETCH;
    end else if (grant_fire) begin
      last_q <= gnt_new;
    end
  end

  assign last_gnt = last_q;
`else
  localparam bit RR_EN = 1'b0;

  assign last_gnt = GNT_FETCH;
`endif

  assign gnt_new = pick_grant(if_req, d_req, last_gnt, RR_EN);

  // Counter runs only while an access is outstanding and restarts from zero
  // on every entry into WAIT_MEM.
  mem_arb_timeout #(
    .TIMEOUT (TIMEOUT),
    .TO_W    (TO_W)
  ) u_timeout (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (state_q != WAIT_MEM),
    .en_i      (state_q == WAIT_MEM),
    .expired_o (to_expired)
  );

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (any_req) state_d = WAIT_MEM;
      WAIT_MEM: if (m_ack || to_expired) state_d = RESP;
      RESP:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    busy   = (state_q != IDLE);
    if_ack = (state_q == RESP) && (gnt_q == GNT_FETCH);
    d_ack  = (state_q == RESP) && (gnt_q == GNT_DATA);
  end

  // ---------------------------------------------------------------------------
  // Datapath next state
  // ---------------------------------------------------------------------------
  always_comb begin
    m_req_d    = m_req_q;
    m_we_d     = m_we_q;
    m_addr_d   = m_addr_q;
    m_wdata_d  = m_wdata_q;
    gnt_d      = gnt_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    err_d      = err_q;

    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          gnt_d   = gnt_new;
          m_req_d = 1'b1;
          if (gnt_new == GNT_DATA) begin
            m_we_d    = d_we;
            m_addr_d  = d_addr;
            m_wdata_d = d_wdata;
          end else begin
            m_we_d    = 1'b0;
            m_addr_d  = if_addr;
            m_wdata_d = '0;
          end
        end
      end

      WAIT_MEM: begin
        // m_ack takes precedence over an expiry in the same cycle.
        if (m_ack) begin
          m_req_d = 1'b0;
          if (!m_we_q) begin
            if (gnt_q == GNT_DATA) d_rdata_d  = m_rdata;
            else                   if_rdata_d = m_rdata;
          end
        end else if (to_expired) begin
          m_req_d = 1'b0;
          err_d   = 1'b1;
          if (!m_we_q) begin
            if (gnt_q == GNT_DATA) d_rdata_d  = '0;
            else                   if_rdata_d = '0;
          end
        end
      end

      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_req_q    <= 1'b0;
      m_we_q     <= 1'b0;
      m_addr_q   <= '0;
      m_wdata_q  <= '0;
      gnt_q      <= GNT_FETCH;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      m_req_q    <= m_req_d;
      m_we_q     <= m_we_d;
      m_addr_q   <= m_addr_d;
      m_wdata_q  <= m_wdata_d;
      gnt_q      <= gnt_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
      err_q      <= err_d;
    end
  end

  assign m_req    = m_req_q;
  assign m_we     = m_we_q;
  assign m_addr   = m_addr_q;
  assign m_wdata  = m_wdata_q;
  assign if_rdata = if_rdata_q;
  assign d_rdata  = d_rdata_q;
  assign err      = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
// Directed plus randomized stimulus for mem_port_arbiter (TIMEOUT = 8).
// A behavioural memory answers m_req after a programmable number of wait
// states; a reference model predicts grant order, memory-side fields,
// latency, returned data and the error flag.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int DATA_W  = 16;
  localparam int ADDR_W  = 16;
  localparam int TIMEOUT = 8;
  localparam int TO_W    = 4;

`ifdef MEM_ARB_RR_EN
  localparam bit RR_ON = 1'b1;
`else
  localparam bit RR_ON = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ack;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_ack;
  logic              m_req;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic [DATA_W-1:0] m_rdata;
  logic              m_ack;
  logic              busy;
  logic              err;

  mem_port_arbiter #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .TIMEOUT (TIMEOUT),
    .TO_W    (TO_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_rdata (if_rdata),
    .if_ack   (if_ack),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_rdata  (d_rdata),
    .d_ack    (d_ack),
    .m_req    (m_req),
    .m_we     (m_we),
    .m_addr   (m_addr),
    .m_wdata  (m_wdata),
    .m_rdata  (m_rdata),
    .m_ack    (m_ack),
    .busy     (busy),
    .err      (err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Memory controls (written only by the main sequence)
  bit mem_on    = 1'b1;
  int mem_delay = 0;
  int stray_req = 0;

  // Memory contents as seen by the behavioural memory, and as predicted.
  logic [DATA_W-1:0] mem     [logic [ADDR_W-1:0]];
  logic [DATA_W-1:0] ref_mem [logic [ADDR_W-1:0]];

  // Reference model state
  logic [DATA_W-1:0] exp_if_rdata;
  logic [DATA_W-1:0] exp_d_rdata;
  bit                exp_err;
  bit                rr_last;   // 0 = fetch granted last, 1 = data

  function automatic logic [DATA_W-1:0] dflt(input logic [ADDR_W-1:0] a);
    return a ^ 16'h5A5A;
  endfunction

  function automatic logic [DATA_W-1:0] ref_rd(input logic [ADDR_W-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Behavioural memory: acks mem_delay cycles after m_req is first seen.
  initial begin
    int cnt;
    int stray_seen;
    cnt        = 0;
    stray_seen = 0;
    m_ack      = 1'b0;
    m_rdata    = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        m_ack = 1'b0;
        cnt   = 0;
      end else if (m_ack) begin
        m_ack = 1'b0;
      end else if (stray_req != stray_seen) begin
        stray_seen = stray_req;
        m_ack      = 1'b1;
        m_rdata    = 16'hDEAD;
      end else if (m_req && mem_on) begin
        if (cnt == mem_delay) begin
          m_ack = 1'b1;
          cnt   = 0;
          if (m_we) mem[m_addr] = m_wdata;
          else      m_rdata = mem.exists(m_addr) ? mem[m_addr] : dflt(m_addr);
        end else begin
          cnt++;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Presents one or two requests together and follows each grant to its ack.
  task automatic run_txn(input bit want_if, input bit want_d,
                         input logic [ADDR_W-1:0] ia, input logic [ADDR_W-1:0] da,
                         input logic [DATA_W-1:0] dwd, input logic dwe,
                         input int dly0, input int dly1, input bit mem_en);
    bit pend_if, pend_d, first, g, got, timed_out;
    int lat, exp_lat, eff, mreq_cycles, dly;
    @(negedge clk);
    if_req    = want_if;
    if_addr   = ia;
    d_req     = want_d;
    d_addr    = da;
    d_we      = dwe;
    d_wdata   = dwd;
    mem_on    = mem_en;
    mem_delay = dly0;
    dly       = dly0;
    pend_if   = want_if;
    pend_d    = want_d;
    first     = 1'b1;
    while (pend_if || pend_d) begin
      if (pend_if && pend_d) g = RR_ON ? !rr_last : 1'b1;
      else                   g = pend_d;
      rr_last   = g;
      timed_out = !mem_en || (dly > TIMEOUT - 1);
      eff       = timed_out ? TIMEOUT - 1 : dly;
      exp_lat   = 2 + eff + (first ? 0 : 1);

      lat = 0; mreq_cycles = 0; got = 1'b0;
      while (!got && lat < 60) begin
        @(negedge clk);
        lat++;
        if (m_req) begin
          mreq_cycles++;
          if (mreq_cycles == 1) begin
            check("m_addr", m_addr, g ? da : ia);
            check("m_we", m_we, g ? dwe : 1'b0);
            if (g && dwe) check("m_wdata", m_wdata, dwd);
            check("busy_wait", busy, 1'b1);
          end
        end
        if (if_ack || d_ack) got = 1'b1;
      end
      check("ack_seen", got, 1'b1);
      check("latency", lat, exp_lat);
      check("m_req_len", mreq_cycles, eff + 1);
      check("ack_port", {if_ack, d_ack}, g ? 2'b01 : 2'b10);

      if (g) begin
        if (dwe) begin
          if (!timed_out) ref_mem[da] = dwd;
        end else begin
          exp_d_rdata = timed_out ? '0 : ref_rd(da);
        end
      end else begin
        exp_if_rdata = timed_out ? '0 : ref_rd(ia);
      end
      if (timed_out) exp_err = 1'b1;
      check("if_rdata", if_rdata, exp_if_rdata);
      check("d_rdata", d_rdata, exp_d_rdata);
      check("err", err, exp_err);

      if (g) begin d_req = 1'b0;  pend_d = 1'b0;  end
      else   begin if_req = 1'b0; pend_if = 1'b0; end
      mem_delay = dly1;
      dly       = dly1;
      first     = 1'b0;
    end
    @(negedge clk);
    check("ack_one_cycle", {if_ack, d_ack}, 2'b00);
  endtask

  initial begin
    logic [ADDR_W-1:0] ra, rb;
    logic [DATA_W-1:0] rw;
    int w, d0, d1;

    rst     = 1'b0;
    if_req  = 1'b0;
    if_addr = '0;
    d_req   = 1'b0;
    d_we    = 1'b0;
    d_addr  = '0;
    d_wdata = '0;
    exp_if_rdata = '0;
    exp_d_rdata  = '0;
    exp_err      = 1'b0;
    rr_last      = 1'b0;

    // Reset state
    #12;
    check("rst_m_req", m_req, 1'b0);
    check("rst_m_we", m_we, 1'b0);
    check("rst_m_addr", m_addr, 16'h0);
    check("rst_m_wdata", m_wdata, 16'h0);
    check("rst_acks", {if_ack, d_ack}, 2'b00);
    check("rst_if_rdata", if_rdata, 16'h0);
    check("rst_d_rdata", d_rdata, 16'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_err", err, 1'b0);
    @(negedge clk);
    rst = 1'b1;

    // Single fetch, memory acks 2 cycles after m_req
    mem[16'h0010]     = 16'hA5C3;
    ref_mem[16'h0010] = 16'hA5C3;
    run_txn(1, 0, 16'h0010, 16'h0000, 16'h0000, 1'b0, 2, 0, 1);
    check("fetch_data", if_rdata, 16'hA5C3);

    // Store with immediate m_ack
    run_txn(0, 1, 16'h0000, 16'h0200, 16'h1234, 1'b1, 0, 0, 1);

    // Simultaneous requests, twice, then a lone data grant before a third pair
    run_txn(1, 1, 16'h0010, 16'h0200, 16'h0000, 1'b0, 1, 1, 1);
    check("tie_load_data", d_rdata, 16'h1234);
    run_txn(1, 1, 16'h0012, 16'h0204, 16'h0000, 1'b0, 0, 2, 1);
    run_txn(0, 1, 16'h0000, 16'h0206, 16'hBEEF, 1'b1, 1, 0, 1);
    run_txn(1, 1, 16'h0014, 16'h0206, 16'h0000, 1'b0, 0, 0, 1);

    // Stray m_ack while idle is ignored
    @(negedge clk);
    stray_req++;
    repeat (3) begin
      @(negedge clk);
      check("stray_busy", busy, 1'b0);
      check("stray_acks", {if_ack, d_ack}, 2'b00);
    end
    check("stray_if_rdata", if_rdata, exp_if_rdata);

    // m_ack in the exact expiry cycle completes normally
    run_txn(1, 0, 16'h0030, 16'h0000, 16'h0000, 1'b0, TIMEOUT - 1, 0, 1);
    check("expiry_no_err", err, 1'b0);

    // Timeout: memory never answers
    run_txn(1, 0, 16'h0040, 16'h0000, 16'h0000, 1'b0, 0, 0, 0);
    check("timeout_err", err, 1'b1);
    run_txn(0, 1, 16'h0000, 16'h0200, 16'h0000, 1'b0, 1, 0, 1);
    check("err_sticky", err, 1'b1);

    // Randomized mix over a small address window so loads hit earlier stores
    for (int i = 0; i < 30; i++) begin
      w  = $urandom_range(1, 3);
      ra = 16'h0100 + 16'($urandom_range(0, 7) * 2);
      rb = 16'h0100 + 16'($urandom_range(0, 7) * 2);
      rw = 16'($urandom());
      d0 = ($urandom_range(0, 9) == 0) ? TIMEOUT + 1 : $urandom_range(0, 4);
      d1 = $urandom_range(0, 4);
      run_txn(w[0], w[1], ra, rb, rw, 1'($urandom_range(0, 1)), d0, d1, 1);
    end

    // Reset in the middle of WAIT_MEM
    @(negedge clk);
    if_req    = 1'b1;
    if_addr   = 16'h0050;
    mem_on    = 1'b1;
    mem_delay = 20;
    repeat (3) @(negedge clk);
    check("pre_rst_m_req", m_req, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    check("mid_rst_m_req", m_req, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_acks", {if_ack, d_ack}, 2'b00);
    check("mid_rst_err", err, 1'b0);
    if_req       = 1'b0;
    exp_if_rdata = '0;
    exp_d_rdata  = '0;
    exp_err      = 1'b0;
    rr_last      = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_busy", busy, 1'b0);
    run_txn(1, 1, 16'h0010, 16'h0060, 16'h0000, 1'b0, 1, 0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
